// File: rtl/im2col_pkg.sv
// Shared types and width helpers for the im2col convolution engine.
package im2col_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        MAC   = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } conv_state_t;

    function automatic int out_w(input int img_w, input int ksize, input int stride);
        return (img_w - ksize) / stride + 1;
    endfunction

    function automatic int out_h(input int img_h, input int ksize, input int stride);
        return (img_h - ksize) / stride + 1;
    endfunction

    function automatic int acc_w(input int data_w, input int ksize);
        return 2 * data_w + $clog2(ksize * ksize);
    endfunction

    // Counter width that never collapses to zero bits for a range of one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/im2col_conv_engine_mac_tree.sv
// KSIZE*KSIZE signed multiply and sum with one registered output.
// Defining IM2COL_RELU_EN clamps negative sums to zero before the register.
module conv_mac_tree
    import im2col_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int KSIZE  = 3,
    parameter int ACC_W  = acc_w(DATA_W, KSIZE)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [KSIZE*KSIZE*DATA_W-1:0]    tap_flat,
    input  logic [KSIZE*KSIZE*DATA_W-1:0]    coef_flat,
    output logic signed [ACC_W-1:0]          acc
);

    localparam int NTAP = KSIZE * KSIZE;
    localparam int PW   = 2 * DATA_W;

    logic signed [PW-1:0]    prod_s [NTAP];
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] result_s;

    // Per-tap products at full precision, then sign-extended accumulation.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NTAP; i++) begin
            prod_s[i] = PW'($signed(tap_flat[i*DATA_W +: DATA_W])) *
                        PW'($signed(coef_flat[i*DATA_W +: DATA_W]));
            sum_s     = sum_s + ACC_W'(prod_s[i]);
        end
    end

    // Optional rectification of the accumulated sum.
    always_comb begin
`ifdef IM2COL_RELU_EN
        if (sum_s[ACC_W-1]) begin
            result_s = '0;
        end else begin
            result_s = sum_s;
        end
`else
        result_s = sum_s;
`endif
    end

    // Result register, loaded only in the MAC cycle so it holds through EMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= result_s;
        end
    end

endmodule

// File: rtl/im2col_conv_engine.sv
// im2col convolution engine: fetches each KSIZE x KSIZE window, MACs it, emits one result.
// Optional IM2COL_RELU_EN (handled inside conv_mac_tree) clamps negative results to zero.
module im2col_conv_engine
    import im2col_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int KSIZE  = 3,
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 30,
    parameter int STRIDE = 1,
    parameter int RD_LAT = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [KSIZE*KSIZE*DATA_W-1:0]              kernel_flat,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       fm_rd_en,
    output logic [$clog2(IMG_W*IMG_H)-1:0]             fm_addr,
    input  logic signed [DATA_W-1:0]                   fm_rdata,
    output logic                                       res_valid,
    input  logic                                       res_ready,
    output logic signed [acc_w(DATA_W, KSIZE)-1:0]     res_data,
    output logic [$clog2(out_w(IMG_W, KSIZE, STRIDE) *
                         out_h(IMG_H, KSIZE, STRIDE))-1:0] res_addr
);

    localparam int OUT_W  = out_w(IMG_W, KSIZE, STRIDE);
    localparam int OUT_H  = out_h(IMG_H, KSIZE, STRIDE);
    localparam int ACC_W  = acc_w(DATA_W, KSIZE);
    localparam int NTAP   = KSIZE * KSIZE;
    localparam int FM_AW  = $clog2(IMG_W * IMG_H);
    localparam int RES_AW = $clog2(OUT_W * OUT_H);
    localparam int XW     = cnt_w(OUT_W);
    localparam int YW     = cnt_w(OUT_H);
    localparam int KW     = cnt_w(KSIZE);
    localparam int IW     = cnt_w(NTAP);
    localparam int DW     = cnt_w(RD_LAT);

    conv_state_t state_r, state_nx_s;
    logic [XW-1:0] ox_r, ox_nx_s;
    logic [YW-1:0] oy_r, oy_nx_s;
    logic [KW-1:0] kx_r, kx_nx_s, ky_r, ky_nx_s;
    logic [IW-1:0] idx_r, idx_nx_s;
    logic [DW-1:0] drain_r, drain_nx_s;
    logic [FM_AW-1:0]  fm_addr_nx_s;
    logic [RES_AW-1:0] res_addr_nx_s;

    logic [NTAP*DATA_W-1:0]   coef_r;
    logic signed [DATA_W-1:0] taps_r [NTAP];
    logic [NTAP*DATA_W-1:0]   tap_flat_s;
    logic                     rd_vld_r [RD_LAT];
    logic [IW-1:0]            rd_idx_r [RD_LAT];
    logic                     mac_en_s;

    // Next-state, counter advance and address generation.
    always_comb begin
        state_nx_s = state_r;
        ox_nx_s    = ox_r;
        oy_nx_s    = oy_r;
        kx_nx_s    = kx_r;
        ky_nx_s    = ky_r;
        idx_nx_s   = idx_r;
        drain_nx_s = drain_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = FETCH;
                    ox_nx_s    = '0;
                    oy_nx_s    = '0;
                    kx_nx_s    = '0;
                    ky_nx_s    = '0;
                    idx_nx_s   = '0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FETCH: begin
                if (idx_r == IW'(NTAP - 1)) begin
                    state_nx_s = DRAIN;
                    kx_nx_s    = '0;
                    ky_nx_s    = '0;
                    idx_nx_s   = '0;
                    drain_nx_s = '0;
                end else begin
                    idx_nx_s = idx_r + IW'(1);
                    if (kx_r == KW'(KSIZE - 1)) begin
                        kx_nx_s = '0;
                        ky_nx_s = ky_r + KW'(1);
                    end else begin
                        kx_nx_s = kx_r + KW'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_r == DW'(RD_LAT - 1)) begin
                    state_nx_s = MAC;
                end else begin
                    drain_nx_s = drain_r + DW'(1);
                end
            end
            MAC: begin
                state_nx_s = EMIT;
            end
            EMIT: begin
                if (res_ready) begin
                    if (ox_r == XW'(OUT_W - 1) && oy_r == YW'(OUT_H - 1)) begin
                        state_nx_s = DONE;
                        ox_nx_s    = '0;
                        oy_nx_s    = '0;
                    end else if (ox_r == XW'(OUT_W - 1)) begin
                        state_nx_s = FETCH;
                        ox_nx_s    = '0;
                        oy_nx_s    = oy_r + YW'(1);
                    end else begin
                        state_nx_s = FETCH;
                        ox_nx_s    = ox_r + XW'(1);
                    end
                end else begin
                    state_nx_s = EMIT;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
        fm_addr_nx_s  = FM_AW'((32'(oy_nx_s) * STRIDE + 32'(ky_nx_s)) * IMG_W +
                               32'(ox_nx_s) * STRIDE + 32'(kx_nx_s));
        res_addr_nx_s = RES_AW'(32'(oy_r) * OUT_W + 32'(ox_r));
    end

    // FSM state and window counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            ox_r    <= '0;
            oy_r    <= '0;
            kx_r    <= '0;
            ky_r    <= '0;
            idx_r   <= '0;
            drain_r <= '0;
        end else begin
            state_r <= state_nx_s;
            ox_r    <= ox_nx_s;
            oy_r    <= oy_nx_s;
            kx_r    <= kx_nx_s;
            ky_r    <= ky_nx_s;
            idx_r   <= idx_nx_s;
            drain_r <= drain_nx_s;
        end
    end

    // Outputs registered from the next state so they line up with state_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            fm_rd_en  <= 1'b0;
            res_valid <= 1'b0;
            fm_addr   <= '0;
            res_addr  <= '0;
            coef_r    <= '0;
        end else begin
            busy      <= (state_nx_s != IDLE);
            done      <= (state_nx_s == DONE);
            fm_rd_en  <= (state_nx_s == FETCH);
            res_valid <= (state_nx_s == EMIT);
            if (state_nx_s == FETCH) begin
                fm_addr <= fm_addr_nx_s;
            end
            if (state_r == MAC) begin
                res_addr <= res_addr_nx_s;
            end
            if (state_r == IDLE && start) begin
                coef_r <= kernel_flat;
            end
        end
    end

    // Read-return tracking: each issued read carries its tap index for RD_LAT cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_vld_r[i] <= 1'b0;
                rd_idx_r[i] <= '0;
            end
            for (int i = 0; i < NTAP; i++) begin
                taps_r[i] <= '0;
            end
        end else begin
            rd_vld_r[0] <= fm_rd_en;
            rd_idx_r[0] <= idx_r;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_r[i] <= rd_vld_r[i-1];
                rd_idx_r[i] <= rd_idx_r[i-1];
            end
            if (rd_vld_r[RD_LAT-1]) begin
                taps_r[rd_idx_r[RD_LAT-1]] <= fm_rdata;
            end
        end
    end

    // Flatten taps for the MAC tree and enable its register only in MAC.
    always_comb begin
        tap_flat_s = '0;
        for (int i = 0; i < NTAP; i++) begin
            tap_flat_s[i*DATA_W +: DATA_W] = taps_r[i];
        end
        mac_en_s = (state_r == MAC);
    end

    conv_mac_tree #(
        .DATA_W (DATA_W),
        .KSIZE  (KSIZE),
        .ACC_W  (ACC_W)
    ) u_mac_tree (
        .clk       (clk),
        .reset     (reset),
        .en        (mac_en_s),
        .tap_flat  (tap_flat_s),
        .coef_flat (coef_r),
        .acc       (res_data)
    );

endmodule

// File: tb/tb_im2col_conv_engine.sv
// Directed bench for im2col_conv_engine: 5x5 stride-1 instance and 7x7 stride-2 instance.
module tb_im2col_conv_engine;

    localparam int DATA_W = 9;
    localparam int KSIZE  = 3;
    localparam int RD_LAT = 2;
    localparam int NTAP   = KSIZE * KSIZE;
    localparam int ACC_W  = 2 * DATA_W + $clog2(NTAP);
    localparam int AW_A   = $clog2(25);
    localparam int RAW_A  = $clog2(9);
    localparam int AW_B   = $clog2(49);
    localparam int RAW_B  = $clog2(9);

    logic clk = 1'b0;
    logic reset;

    logic                      start_a, busy_a, done_a, fm_rd_en_a, res_valid_a, res_ready_a;
    logic [NTAP*DATA_W-1:0]    kernel_a;
    logic [AW_A-1:0]           fm_addr_a;
    logic signed [DATA_W-1:0]  fm_rdata_a;
    logic signed [ACC_W-1:0]   res_data_a;
    logic [RAW_A-1:0]          res_addr_a;

    logic                      start_b, busy_b, done_b, fm_rd_en_b, res_valid_b, res_ready_b;
    logic [NTAP*DATA_W-1:0]    kernel_b;
    logic [AW_B-1:0]           fm_addr_b;
    logic signed [DATA_W-1:0]  fm_rdata_b;
    logic signed [ACC_W-1:0]   res_data_b;
    logic [RAW_B-1:0]          res_addr_b;

    int mem_a [32];
    int mem_b [64];
    logic [AW_A-1:0] pipe_a [RD_LAT];
    logic [AW_B-1:0] pipe_b [RD_LAT];

    int raddr_a[$], rdata_a[$], faddr_a[$];
    int raddr_b[$], rdata_b[$], faddr_b[$];
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int vec_cnt = 0;
    int err_cnt = 0;

    im2col_conv_engine #(
        .DATA_W(DATA_W), .KSIZE(KSIZE), .IMG_W(5), .IMG_H(5), .STRIDE(1), .RD_LAT(RD_LAT)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .kernel_flat(kernel_a),
        .busy(busy_a), .done(done_a), .fm_rd_en(fm_rd_en_a), .fm_addr(fm_addr_a),
        .fm_rdata(fm_rdata_a), .res_valid(res_valid_a), .res_ready(res_ready_a),
        .res_data(res_data_a), .res_addr(res_addr_a)
    );

    im2col_conv_engine #(
        .DATA_W(DATA_W), .KSIZE(KSIZE), .IMG_W(7), .IMG_H(7), .STRIDE(2), .RD_LAT(RD_LAT)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .kernel_flat(kernel_b),
        .busy(busy_b), .done(done_b), .fm_rd_en(fm_rd_en_b), .fm_addr(fm_addr_b),
        .fm_rdata(fm_rdata_b), .res_valid(res_valid_b), .res_ready(res_ready_b),
        .res_data(res_data_b), .res_addr(res_addr_b)
    );

    always #5 clk = ~clk;

    // Feature memories with RD_LAT-cycle read latency.
    always @(posedge clk) begin
        pipe_a[0] <= fm_addr_a;
        pipe_b[0] <= fm_addr_b;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign fm_rdata_a = DATA_W'(mem_a[pipe_a[RD_LAT-1]]);
    assign fm_rdata_b = DATA_W'(mem_b[pipe_b[RD_LAT-1]]);

    // Record handshakes, issued reads and done pulses away from the active edge.
    always @(negedge clk) begin
        if (res_valid_a && res_ready_a) begin
            raddr_a.push_back(int'(res_addr_a));
            rdata_a.push_back(int'(res_data_a));
        end
        if (res_valid_b && res_ready_b) begin
            raddr_b.push_back(int'(res_addr_b));
            rdata_b.push_back(int'(res_data_b));
        end
        if (fm_rd_en_a) faddr_a.push_back(int'(fm_addr_a));
        if (fm_rd_en_b) faddr_b.push_back(int'(fm_addr_b));
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -99999;
    endfunction

    task automatic set_kernel_a(input int v);
        for (int i = 0; i < NTAP; i++) kernel_a[i*DATA_W +: DATA_W] = DATA_W'(v);
    endtask

    task automatic fill_a(input int mode, input int v);
        for (int i = 0; i < 32; i++) mem_a[i] = (mode == 0) ? i + 1 : v;
    endtask

    task automatic clear_a();
        raddr_a.delete(); rdata_a.delete(); faddr_a.delete();
    endtask

    // Pulse start, run until done (bounded); lat = cycles from FETCH entry to res_valid.
    task automatic frame_a(output int lat);
        int n;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        lat = -1;
        n = 0;
        while (!done_a && n < 2000) begin
            if (res_valid_a && lat < 0) lat = n;
            @(posedge clk); #1;
            n++;
        end
        check_eq("frame_done_a", longint'(done_a), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic int exp_ones_a(input int k);
        return 9 * (((k / 3) + 1) * 5 + (k % 3) + 2);
    endfunction

    initial begin
        int lat, d0, n, stable, rd0;
        int neg_exp;
`ifdef IM2COL_RELU_EN
        neg_exp = 0;
`else
        neg_exp = -900;
`endif
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        res_ready_a = 1'b1; res_ready_b = 1'b1;
        kernel_a = '0; kernel_b = '0;
        fill_a(0, 0);
        for (int i = 0; i < 64; i++) mem_b[i] = i + 1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_valid", res_valid_a, 0);
        check_eq("rst_rd_en", fm_rd_en_a, 0);
        check_eq("rst_fm_addr", fm_addr_a, 0);
        check_eq("rst_res_addr", res_addr_a, 0);
        check_eq("rst_res_data", res_data_a, 0);

        // Image 1..25, all-ones kernel
        set_kernel_a(1);
        clear_a();
        d0 = done_cnt_a;
        frame_a(lat);
        check_eq("latency", lat, 12);
        check_eq("ones_count", raddr_a.size(), 9);
        for (int k = 0; k < 9; k++) begin
            check_eq($sformatf("ones_addr%0d", k), qget(raddr_a, k), k);
            check_eq($sformatf("ones_data%0d", k), qget(rdata_a, k), exp_ones_a(k));
            check_eq($sformatf("ones_fm%0d", k), qget(faddr_a, k), (k / 3) * 5 + (k % 3));
        end
        check_eq("ones_fm_out1", qget(faddr_a, 9), 1);
        check_eq("ones_reads", faddr_a.size(), 81);
        check_eq("ones_done", done_cnt_a - d0, 1);

        // Kernel all -1, pixels 100
        set_kernel_a(-1);
        fill_a(1, 100);
        clear_a();
        frame_a(lat);
        check_eq("neg_count", rdata_a.size(), 9);
        for (int k = 0; k < 9; k++) check_eq($sformatf("neg_data%0d", k), qget(rdata_a, k), neg_exp);

        // Extreme operands: -256 * -256 over nine taps
        set_kernel_a(-256);
        fill_a(1, -256);
        clear_a();
        frame_a(lat);
        check_eq("max_data0", qget(rdata_a, 0), 589824);
        check_eq("max_data8", qget(rdata_a, 8), 589824);

        // Back-pressure: hold res_ready low for 10 cycles in EMIT
        set_kernel_a(1);
        fill_a(0, 0);
        clear_a();
        d0 = done_cnt_a;
        res_ready_a = 1'b0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (!res_valid_a && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("stall_reach", res_valid_a, 1);
        rd0 = faddr_a.size();
        stable = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (res_valid_a && res_data_a == 63 && res_addr_a == 0) stable++;
        end
        check_eq("stall_stable", stable, 10);
        check_eq("stall_no_reads", faddr_a.size() - rd0, 0);
        res_ready_a = 1'b1;
        n = 0;
        while (!done_a && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("stall_frame_done", done_a, 1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("stall_count", raddr_a.size(), 9);
        check_eq("stall_first", qget(rdata_a, 0), 63);
        check_eq("stall_done", done_cnt_a - d0, 1);

        // Reset during FETCH of output 4, then restart
        clear_a();
        d0 = done_cnt_a;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (!(raddr_a.size() == 4 && fm_rd_en_a) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("abort_reach", fm_rd_en_a, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_busy", busy_a, 0);
        check_eq("abort_valid", res_valid_a, 0);
        check_eq("abort_rd_en", fm_rd_en_a, 0);
        check_eq("abort_fm_addr", fm_addr_a, 0);
        check_eq("abort_res_data", res_data_a, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt_a - d0, 0);
        clear_a();
        frame_a(lat);
        check_eq("restart_addr0", qget(raddr_a, 0), 0);
        check_eq("restart_data0", qget(rdata_a, 0), 63);
        check_eq("restart_count", raddr_a.size(), 9);
        check_eq("restart_done", done_cnt_a - d0, 1);

        // start while busy and kernel change mid-frame are ignored
        clear_a();
        d0 = done_cnt_a;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        start_a = 1'b1;
        set_kernel_a(2);
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("busy_frame_done", done_a, 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("busy_count", rdata_a.size(), 9);
        check_eq("busy_data0", qget(rdata_a, 0), 63);
        check_eq("busy_data8", qget(rdata_a, 8), 171);
        check_eq("busy_done", done_cnt_a - d0, 1);
        check_eq("busy_no_restart", busy_a, 0);

        // Stride 2 on a 7x7 image, all-ones kernel
        for (int i = 0; i < NTAP; i++) kernel_b[i*DATA_W +: DATA_W] = DATA_W'(1);
        d0 = done_cnt_b;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("s2_frame_done", done_b, 1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("s2_count", rdata_b.size(), 9);
        check_eq("s2_fm_out1", qget(faddr_b, 9), 2);
        check_eq("s2_data0", qget(rdata_b, 0), 81);
        check_eq("s2_data4", qget(rdata_b, 4), 225);
        check_eq("s2_data8", qget(rdata_b, 8), 369);
        check_eq("s2_addr8", qget(raddr_b, 8), 8);
        check_eq("s2_done", done_cnt_b - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vec_cnt);
        $fatal(1, "watchdog");
    end

endmodule
